// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller.
//   - FSM state encoding, as an enum and as legacy localparam constants
//   - parity select constants
//   - frame length helper, in bit periods
// Optional feature macro: UART_TX_PARITY_EN (consumed by uart_tx_ctrl).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    E_IDLE   = 3'd0,
    E_ARM    = 3'd1,
    E_START  = 3'd2,
    E_DATA   = 3'd3,
    E_PARITY = 3'd4,
    E_STOP   = 3'd5
  } uart_tx_state_e;

  localparam logic [2:0] ST_IDLE   = E_IDLE;
  localparam logic [2:0] ST_ARM    = E_ARM;
  localparam logic [2:0] ST_START  = E_START;
  localparam logic [2:0] ST_DATA   = E_DATA;
  localparam logic [2:0] ST_PARITY = E_PARITY;
  localparam logic [2:0] ST_STOP   = E_STOP;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // start + data + optional parity + stop bits
  function automatic int unsigned uart_frame_len(input int unsigned data_width,
                                                 input int unsigned stop_bits,
                                                 input bit          parity_en);
    return 1 + data_width + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Payload shift register and data-bit counter for the UART transmitter.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_load          capture i_data and clear the bit counter
//   i_shift         shift right by one and count one data bit
//   i_data          payload to capture
//   o_bit0          bit currently on the line during DATA
//   o_bit1          bit that becomes o_bit0 after the next shift
//   o_last          counter is on the final data bit
module uart_tx_shifter
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit0,
  output logic                  o_bit1,
  output logic                  o_last
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_bit0 = r_shift[0];
  assign o_bit1 = r_shift[1];
  assign o_last = (r_cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: Send/Ready handshake, frame sequencing paced by
// an external baud tick, registered serial output and a frame-done pulse.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after data.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_baud_tick     one-cycle enable per bit period
//   i_send          transmit request, honoured only while o_ready
//   i_data_in       payload, captured on acceptance
//   i_parity_odd    1 = odd, 0 = even parity (ignored without the feature)
//   o_tx_out        serial line, idle high
//   o_ready         block is idle and can accept i_send
//   o_busy          frame in progress
//   o_done_flag     one-cycle pulse on the first idle cycle after a frame
//
// state  | meaning
// IDLE   | line high, waiting for i_send
// ARM    | line high, waiting for a tick so the start bit is a full period
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (feature builds only)
// STOP   | stop bit(s), high
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_baud_tick,
  input  logic                  i_send,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_parity_odd,
  output logic                  o_tx_out,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done_flag
);

  // stop-bit down-counter preload: remaining ticks after the first one
  localparam logic STOP_LOAD = (STOP_BITS == 2);

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic       r_tx;
  logic       w_tx_next;
  logic       r_done;
  logic       w_done_next;
  logic       r_stop_left;
  logic       w_accept;
  logic       w_shift;
  logic       w_bit0;
  logic       w_bit1;
  logic       w_last;

  assign w_accept = (r_state == ST_IDLE) && i_send;
  assign w_shift  = (r_state == ST_DATA) && i_baud_tick;

  uart_tx_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (i_data_in),
    .o_bit0  (w_bit0),
    .o_bit1  (w_bit1),
    .o_last  (w_last)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is resolved at acceptance because the shifter destroys the payload.
  logic r_par_bit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_par_bit <= (^i_data_in) ^ (i_parity_odd == PARITY_ODD);
    end
  end
`else
  logic w_unused_parity;
  assign w_unused_parity = i_parity_odd;
`endif

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_send) w_state_next = ST_ARM;
      ST_ARM:   if (i_baud_tick) w_state_next = ST_START;
      ST_START: if (i_baud_tick) w_state_next = ST_DATA;
      ST_DATA: begin
        if (i_baud_tick && w_last) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (i_baud_tick) w_state_next = ST_STOP;
`endif
      ST_STOP: begin
        if (i_baud_tick && !r_stop_left) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Line value follows the next state so o_tx_out is a plain flop; inside
  // DATA a tick shifts the register, so the upcoming bit is bit1.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = (r_state == ST_DATA && i_baud_tick) ? w_bit1 : w_bit0;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_next = r_par_bit;
`endif
      default:   w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_stop_left <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
      if (r_state != ST_STOP) begin
        r_stop_left <= STOP_LOAD;
      end else if (i_baud_tick) begin
        r_stop_left <= 1'b0;
      end
    end
  end

  assign o_tx_out    = r_tx;
  assign o_ready     = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done_flag = r_done;

endmodule
